axi_master_bridge: RTL and testbench

Parametrised AXI4 master that replaces the fixed-width, single-ID fetch/load/store bus interface.
- Arbitrates two clients onto one AXI4 port: instruction fetch (IF, read-only, bursts up to MAX_BURST beats) and load/store unit (LSU, single-beat read or write).
- Clients use valid/ready handshakes.
- Adds lane alignment, correct AxSIZE/WSTRB derivation, RLAST-checked bursts and error reporting.

---
 rtl/axi_pkg.sv | 57 +++++
 rtl/axi_lane_align.sv | 51 +++++
 rtl/axi_master_bridge.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axi_master_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 encodings and bridge state types.
//                AXSIZE_* / AXBURST_INCR / XRESP_* encodings, read and write
//                FSM state enums, and a helper mapping a byte count to AxSIZE.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_pkg;

    localparam logic [2:0] AXSIZE_1   = 3'd0;
    localparam logic [2:0] AXSIZE_2   = 3'd1;
    localparam logic [2:0] AXSIZE_4   = 3'd2;
    localparam logic [2:0] AXSIZE_8   = 3'd3;
    localparam logic [2:0] AXSIZE_16  = 3'd4;
    localparam logic [2:0] AXSIZE_32  = 3'd5;
    localparam logic [2:0] AXSIZE_64  = 3'd6;
    localparam logic [2:0] AXSIZE_128 = 3'd7;

    localparam logic [1:0] AXBURST_INCR = 2'b01;

    localparam logic [1:0] XRESP_OKAY   = 2'b00;
    localparam logic [1:0] XRESP_EXOKAY = 2'b01;
    localparam logic [1:0] XRESP_SLVERR = 2'b10;
    localparam logic [1:0] XRESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // AxSIZE encoding for a full-width beat of nbytes bytes.
    function automatic logic [2:0] axsize_from_bytes(input int unsigned nbytes);
        logic [2:0] sz;
        case (nbytes)
            32'd1:   sz = AXSIZE_1;
            32'd2:   sz = AXSIZE_2;
            32'd4:   sz = AXSIZE_4;
            32'd8:   sz = AXSIZE_8;
            32'd16:  sz = AXSIZE_16;
            32'd32:  sz = AXSIZE_32;
            32'd64:  sz = AXSIZE_64;
            32'd128: sz = AXSIZE_128;
            default: sz = AXSIZE_1;
        endcase
        return sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lane_align
//  Description : Byte-lane alignment for sub-word LSU accesses.
//                Ports: offset/size select the lanes; wdata_in -> wdata_out
//                shifted up to the lane, wstrb the matching byte strobe;
//                rdata_in -> rdata_out shifted down to bit 0 and masked to size.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_lane_align
    import axi_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [1:0]                  size,
    input  logic [DATA_W-1:0]           wdata_in,
    output logic [DATA_W-1:0]           wdata_out,
    output logic [DATA_W/8-1:0]         wstrb,
    input  logic [DATA_W-1:0]           rdata_in,
    output logic [DATA_W-1:0]           rdata_out
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    logic [BYTES-1:0]  w_size_bytes;
    logic [DATA_W-1:0] w_size_bits;
    logic [DATA_W-1:0] w_rd_shift;
    logic [OFF_W+2:0]  w_bit_off;

    // Low (1 << size) bytes set, i.e. ((1 << (1 << size)) - 1).
    always_comb begin
        w_size_bytes = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_size_bytes[i] = (i < (1 << size));
        end
    end

    for (genvar b = 0; b < BYTES; b++) begin : g_mask
        assign w_size_bits[8*b +: 8] = {8{w_size_bytes[b]}};
    end

    assign w_bit_off  = {offset, 3'b000};
    assign wstrb      = w_size_bytes << offset;
    assign wdata_out  = wdata_in << w_bit_off;
    assign w_rd_shift = rdata_in >> w_bit_off;
    assign rdata_out  = w_rd_shift & w_size_bits;

endmodule
`default_nettype wire

// File: rtl/axi_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axi_master_bridge
//  Description : Two-client AXI4 master. IF (read bursts) and LSU (single-beat
//                read/write) share one AXI4 port; one read outstanding at a
//                time, an IF read may overlap an LSU write.
//                Ports: if_req_*/if_rsp_* fetch client, lsu_req_*/lsu_rsp_*
//                load/store client, axi_ar/r/aw/w/b* AXI4 master channels.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_master_bridge
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MAX_BURST = 8,
    parameter int ID_IF     = 0,
    parameter int ID_LSU    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          if_req_valid,
    output logic                          if_req_ready,
    input  logic [ADDR_W-1:0]             if_req_addr,
    input  logic [$clog2(MAX_BURST)-1:0]  if_req_len,
    output logic                          if_rsp_valid,
    output logic [DATA_W-1:0]             if_rsp_data,
    output logic                          if_rsp_last,
    output logic                          if_rsp_err,
    input  logic                          lsu_req_valid,
    output logic                          lsu_req_ready,
    input  logic                          lsu_req_wen,
    input  logic [ADDR_W-1:0]             lsu_req_addr,
    input  logic [1:0]                    lsu_req_size,
    input  logic [DATA_W-1:0]             lsu_req_wdata,
    output logic                          lsu_rsp_valid,
    output logic [DATA_W-1:0]             lsu_rsp_rdata,
    output logic                          lsu_rsp_err,
    output logic [ID_W-1:0]               axi_arid,
    output logic [ADDR_W-1:0]             axi_araddr,
    output logic [7:0]                    axi_arlen,
    output logic [2:0]                    axi_arsize,
    output logic [1:0]                    axi_arburst,
    output logic                          axi_arvalid,
    input  logic                          axi_arready,
    input  logic [ID_W-1:0]               axi_rid,
    input  logic [DATA_W-1:0]             axi_rdata,
    input  logic [1:0]                    axi_rresp,
    input  logic                          axi_rlast,
    input  logic                          axi_rvalid,
    output logic                          axi_rready,
    output logic [ID_W-1:0]               axi_awid,
    output logic [ADDR_W-1:0]             axi_awaddr,
    output logic [7:0]                    axi_awlen,
    output logic [2:0]                    axi_awsize,
    output logic [1:0]                    axi_awburst,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [DATA_W-1:0]             axi_wdata,
    output logic [DATA_W/8-1:0]           axi_wstrb,
    output logic                          axi_wlast,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [ID_W-1:0]               axi_bid,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready
);

    localparam int              BYTES     = DATA_W / 8;
    localparam int              OFF_W     = $clog2(BYTES);
    localparam logic [ID_W-1:0] C_ID_IF   = ID_W'(ID_IF);
    localparam logic [ID_W-1:0] C_ID_LSU  = ID_W'(ID_LSU);
    localparam logic [2:0]      C_IF_SIZE = axsize_from_bytes(BYTES);

    rd_state_e          rd_state_q, rd_state_d;
    wr_state_e          wr_state_q, wr_state_d;
    logic               rr_last_q, rr_last_d;      // 1: LSU won the last tie
    logic               rd_owner_q, rd_owner_d;    // 1: current read is LSU
    logic [ADDR_W-1:0]  ar_addr_q, ar_addr_d;
    logic [7:0]         ar_len_q, ar_len_d;
    logic [2:0]         ar_size_q, ar_size_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic               lsu_busy_q, lsu_busy_d;
    logic [ADDR_W-1:0]  lsu_addr_q, lsu_addr_d;
    logic [1:0]         lsu_size_q, lsu_size_d;
    logic [DATA_W-1:0]  lsu_wdata_q, lsu_wdata_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;

    logic               w_lsu_wr_req, w_lsu_rd_req, w_if_rd_req, w_tie;
    logic               w_grant_lsu_rd, w_grant_if;
    logic               w_rbeat, w_last_exp, w_rd_bad;
    logic               w_lsu_rd_done, w_lsu_wr_done;
    logic [ID_W-1:0]    w_rid_exp;
    logic [DATA_W-1:0]  w_rd_aligned;

    // A pending LSU write holds IF off for that cycle so the two client
    // readies are never raised together.
    assign w_lsu_wr_req   = lsu_req_valid & lsu_req_wen & ~lsu_busy_q;
    assign w_lsu_rd_req   = lsu_req_valid & ~lsu_req_wen & ~lsu_busy_q & (rd_state_q == R_IDLE);
    assign w_if_rd_req    = if_req_valid & (rd_state_q == R_IDLE) & ~w_lsu_wr_req;
    assign w_tie          = w_lsu_rd_req & w_if_rd_req;
    assign w_grant_lsu_rd = w_lsu_rd_req & (~w_if_rd_req | ~rr_last_q);
    assign w_grant_if     = w_if_rd_req & ~w_grant_lsu_rd;

    assign if_req_ready   = w_grant_if & ~rst;
    assign lsu_req_ready  = (w_grant_lsu_rd | w_lsu_wr_req) & ~rst;

    assign w_rbeat        = (rd_state_q == R_DATA) & axi_rvalid;
    assign w_last_exp     = (beat_cnt_q == ar_len_q);
    assign w_rid_exp      = rd_owner_q ? C_ID_LSU : C_ID_IF;
    assign w_rd_bad       = (axi_rresp != XRESP_OKAY) | (axi_rid != w_rid_exp);
    assign w_lsu_rd_done  = w_rbeat & rd_owner_q;
    assign w_lsu_wr_done  = (wr_state_q == W_RESP) & axi_bvalid;

    axi_lane_align #(.DATA_W(DATA_W)) u_align (
        .offset    (lsu_addr_q[OFF_W-1:0]),
        .size      (lsu_size_q),
        .wdata_in  (lsu_wdata_q),
        .wdata_out (axi_wdata),
        .wstrb     (axi_wstrb),
        .rdata_in  (axi_rdata),
        .rdata_out (w_rd_aligned)
    );

    assign if_rsp_valid  = w_rbeat & ~rd_owner_q;
    assign if_rsp_data   = axi_rdata;
    assign if_rsp_last   = w_last_exp;
    assign if_rsp_err    = w_rd_bad | (axi_rlast != w_last_exp);

    assign lsu_rsp_valid = w_lsu_rd_done | w_lsu_wr_done;
    assign lsu_rsp_rdata = w_lsu_rd_done ? w_rd_aligned : '0;
    assign lsu_rsp_err   = w_lsu_rd_done ? w_rd_bad
                         : ((axi_bresp != XRESP_OKAY) | (axi_bid != C_ID_LSU));

    assign axi_arid      = w_rid_exp;
    assign axi_araddr    = ar_addr_q;
    assign axi_arlen     = ar_len_q;
    assign axi_arsize    = ar_size_q;
    assign axi_arburst   = AXBURST_INCR;
    assign axi_arvalid   = (rd_state_q == R_AR);
    assign axi_rready    = (rd_state_q == R_DATA);

    assign axi_awid      = C_ID_LSU;
    assign axi_awaddr    = lsu_addr_q;
    assign axi_awlen     = 8'd0;
    assign axi_awsize    = {1'b0, lsu_size_q};
    assign axi_awburst   = AXBURST_INCR;
    assign axi_awvalid   = awvalid_q;
    assign axi_wlast     = 1'b1;
    assign axi_wvalid    = wvalid_q;
    assign axi_bready    = (wr_state_q == W_RESP);

    always_comb begin
        rd_state_d  = rd_state_q;
        wr_state_d  = wr_state_q;
        rr_last_d   = rr_last_q;
        rd_owner_d  = rd_owner_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        beat_cnt_d  = beat_cnt_q;
        lsu_busy_d  = lsu_busy_q;
        lsu_addr_d  = lsu_addr_q;
        lsu_size_d  = lsu_size_q;
        lsu_wdata_d = lsu_wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;

        if (w_grant_lsu_rd | w_lsu_wr_req) begin
            lsu_busy_d  = 1'b1;
            lsu_addr_d  = lsu_req_addr;
            lsu_size_d  = lsu_req_size;
            lsu_wdata_d = lsu_req_wdata;
        end else if (lsu_rsp_valid) begin
            lsu_busy_d  = 1'b0;
        end

        case (rd_state_q)
            R_IDLE: begin
                beat_cnt_d = 8'd0;
                if (w_tie) rr_last_d = w_grant_lsu_rd;
                if (w_grant_if) begin
                    ar_addr_d  = if_req_addr;
                    ar_len_d   = 8'(if_req_len);
                    ar_size_d  = C_IF_SIZE;
                    rd_owner_d = 1'b0;
                    rd_state_d = R_AR;
                end else if (w_grant_lsu_rd) begin
                    ar_addr_d  = lsu_req_addr;
                    ar_len_d   = 8'd0;
                    ar_size_d  = {1'b0, lsu_req_size};
                    rd_owner_d = 1'b1;
                    rd_state_d = R_AR;
                end
            end
            R_AR:    if (axi_arready) rd_state_d = R_DATA;
            R_DATA: begin
                // The burst ends on the expected beat count, whatever RLAST says.
                if (w_rbeat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_last_exp) rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        case (wr_state_q)
            W_IDLE: begin
                if (w_lsu_wr_req) begin
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    wr_state_d = W_SEND;
                end
            end
            W_SEND: begin
                if (awvalid_q & axi_awready) awvalid_d = 1'b0;
                if (wvalid_q & axi_wready)   wvalid_d  = 1'b0;
                if (~awvalid_d & ~wvalid_d)  wr_state_d = W_RESP;
            end
            W_RESP:  if (axi_bvalid) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q  <= R_IDLE;
            wr_state_q  <= W_IDLE;
            rr_last_q   <= 1'b1;
            rd_owner_q  <= 1'b0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            ar_size_q   <= '0;
            beat_cnt_q  <= '0;
            lsu_busy_q  <= 1'b0;
            lsu_addr_q  <= '0;
            lsu_size_q  <= '0;
            lsu_wdata_q <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_state_q  <= wr_state_d;
            rr_last_q   <= rr_last_d;
            rd_owner_q  <= rd_owner_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            ar_size_q   <= ar_size_d;
            beat_cnt_q  <= beat_cnt_d;
            lsu_busy_q  <= lsu_busy_d;
            lsu_addr_q  <= lsu_addr_d;
            lsu_size_q  <= lsu_size_d;
            lsu_wdata_q <= lsu_wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_master_bridge
//  Description : Directed self-checking bench for axi_master_bridge; the bench
//                plays the AXI slave cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_master_bridge;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [63:0] if_req_addr;
    logic [2:0]  if_req_len;
    logic        if_rsp_valid, if_rsp_last, if_rsp_err;
    logic [63:0] if_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [63:0] lsu_req_addr, lsu_req_wdata;
    logic [1:0]  lsu_req_size;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [63:0] lsu_rsp_rdata;
    logic [3:0]  axi_arid, axi_rid, axi_awid, axi_bid;
    logic [63:0] axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
    logic [7:0]  axi_arlen, axi_awlen, axi_wstrb;
    logic [2:0]  axi_arsize, axi_awsize;
    logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
    logic        axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready;

    int n_vec = 0;
    int n_err = 0;

    axi_master_bridge dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr), .if_req_len(if_req_len),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .if_rsp_last(if_rsp_last), .if_rsp_err(if_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_size(lsu_req_size), .lsu_req_wdata(lsu_req_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .lsu_rsp_err(lsu_rsp_err),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the rising edge; inputs are then driven and sampled
    // after a further 1 ns of settling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_if_read(input logic [63:0] addr, input logic [2:0] len, input int ar_wait,
                              input logic [7:0] rlast_bits, input logic [7:0] exp_err);
        if_req_valid = 1'b1; if_req_addr = addr; if_req_len = len;
        #1;
        chk("if_req_ready", {if_req_ready, lsu_req_ready}, 2'b10);
        tick();
        if_req_valid = 1'b0;
        #1;
        chk("if_ar_fields", {axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst},
            {1'b1, 4'd0, 5'd0, len, 3'd3, 2'b01});
        chk("if_araddr", axi_araddr, addr);
        for (int w = 0; w < ar_wait; w++) begin
            tick(); #1;
            chk("if_ar_hold", {axi_arvalid, (axi_araddr == addr)}, 2'b11);
        end
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        #1;
        chk("if_rready", {axi_rready, axi_arvalid}, 2'b10);
        for (int b = 0; b <= int'(len); b++) begin
            axi_rvalid = 1'b1; axi_rid = 4'd0; axi_rresp = 2'b00;
            axi_rlast  = rlast_bits[b];
            axi_rdata  = {addr[31:0], 32'(b) + 32'hBEEF_0000};
            #1;
            chk("if_beat_ctl", {if_rsp_valid, if_rsp_last, if_rsp_err},
                {1'b1, (b == int'(len)), exp_err[b]});
            chk("if_beat_data", if_rsp_data, {addr[31:0], 32'(b) + 32'hBEEF_0000});
            tick();
        end
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        #1;
        chk("if_done_idle", {axi_rready, if_rsp_valid}, 2'b00);
    endtask

    task automatic do_lsu_read(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] rdata,
                               input logic [1:0] rresp, input logic [3:0] rid,
                               input logic [63:0] exp_rdata, input logic exp_err);
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = addr; lsu_req_size = size;
        #1;
        chk("lsu_rd_ready", {lsu_req_ready, if_req_ready}, 2'b10);
        tick();
        lsu_req_valid = 1'b0;
        #1;
        chk("lsu_ar_fields", {axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst},
            {1'b1, 4'd1, 8'd0, 1'b0, size, 2'b01});
        chk("lsu_araddr", axi_araddr, addr);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        axi_rvalid = 1'b1; axi_rid = rid; axi_rresp = rresp; axi_rlast = 1'b1; axi_rdata = rdata;
        #1;
        chk("lsu_rd_rsp", {lsu_rsp_valid, lsu_rsp_err, if_rsp_valid}, {1'b1, exp_err, 1'b0});
        chk("lsu_rd_data", lsu_rsp_rdata, exp_rdata);
        tick();
        axi_rvalid = 1'b0; axi_rlast = 1'b0;
        #1;
        chk("lsu_rd_done", {lsu_rsp_valid, axi_rready}, 2'b00);
    endtask

    // mode 0: AWREADY first, 1: WREADY first, other: both in the same cycle
    task automatic do_lsu_write(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wdata,
                                input int mode, input logic [1:0] bresp, input logic [7:0] exp_strb,
                                input logic [63:0] exp_wdata, input logic exp_err);
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = addr;
        lsu_req_size = size; lsu_req_wdata = wdata;
        #1;
        chk("lsu_wr_ready", {lsu_req_ready, if_req_ready}, 2'b10);
        tick();
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
        #1;
        chk("aw_fields", {axi_awvalid, axi_wvalid, axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_wlast},
            {2'b11, 4'd1, 8'd0, 1'b0, size, 2'b01, 1'b1});
        chk("awaddr", axi_awaddr, addr);
        chk("wstrb", axi_wstrb, exp_strb);
        chk("wdata", axi_wdata, exp_wdata);
        if (mode == 0) begin
            axi_awready = 1'b1; tick(); axi_awready = 1'b0; #1;
            chk("aw_first", {axi_awvalid, axi_wvalid, axi_bready}, 3'b010);
            axi_wready = 1'b1; tick(); axi_wready = 1'b0;
        end else if (mode == 1) begin
            axi_wready = 1'b1; tick(); axi_wready = 1'b0; #1;
            chk("w_first", {axi_awvalid, axi_wvalid, axi_bready}, 3'b100);
            axi_awready = 1'b1; tick(); axi_awready = 1'b0;
        end else begin
            axi_awready = 1'b1; axi_wready = 1'b1; tick();
            axi_awready = 1'b0; axi_wready = 1'b0;
        end
        #1;
        chk("wr_resp_wait", {axi_awvalid, axi_wvalid, axi_bready, lsu_rsp_valid}, 4'b0010);
        lsu_req_valid = 1'b1;
        #1;
        chk("lsu_busy", lsu_req_ready, 1'b0);
        lsu_req_valid = 1'b0;
        tick();
        axi_bvalid = 1'b1; axi_bid = 4'd1; axi_bresp = bresp;
        #1;
        chk("wr_ack", {lsu_rsp_valid, lsu_rsp_err}, {1'b1, exp_err});
        tick();
        axi_bvalid = 1'b0;
        #1;
        chk("wr_done", {axi_bready, lsu_rsp_valid}, 2'b00);
    endtask

    initial begin
        rst = 1'b0;
        if_req_valid = 1'b1; if_req_addr = '0; if_req_len = '0;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = '0;
        lsu_req_size = '0; lsu_req_wdata = '0;
        axi_arready = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0;
        axi_rlast = 1'b0; axi_rvalid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
        axi_bid = '0; axi_bresp = '0; axi_bvalid = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        chk("rst_outs", {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready,
                         if_req_ready, lsu_req_ready, if_rsp_valid, lsu_rsp_valid}, 9'd0);
        if_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
        rst = 1'b0;
        tick();

        // IF burst of 4 with ARREADY held off for 2 cycles
        do_if_read(64'h8000_0000, 3'd3, 2, 8'b0000_1000, 8'h00);

        // Half-word write at byte 5, three AW/W orderings
        do_lsu_write(64'h8000_0005, 2'd1, 64'hABCD, 0, 2'b00, 8'h60, 64'h00AB_CD00_0000_0000, 1'b0);
        do_lsu_write(64'h8000_0005, 2'd1, 64'hABCD, 1, 2'b00, 8'h60, 64'h00AB_CD00_0000_0000, 1'b0);
        do_lsu_write(64'h8000_0005, 2'd1, 64'hABCD, 2, 2'b00, 8'h60, 64'h00AB_CD00_0000_0000, 1'b0);
        do_lsu_write(64'h8000_0000, 2'd3, 64'h0123_4567_89AB_CDEF, 2, 2'b00, 8'hFF,
                     64'h0123_4567_89AB_CDEF, 1'b0);
        do_lsu_write(64'h8000_0003, 2'd0, 64'h5A, 0, 2'b10, 8'h08, 64'h0000_0000_5A00_0000, 1'b1);

        // LSU reads: lane extraction, SLVERR, RID mismatch
        do_lsu_read(64'h8000_0004, 2'd2, 64'h1122_3344_5566_7788, 2'b00, 4'd1, 64'h1122_3344, 1'b0);
        do_lsu_read(64'h8000_0006, 2'd1, 64'h1122_3344_5566_7788, 2'b00, 4'd1, 64'h1122, 1'b0);
        do_lsu_read(64'h8000_0001, 2'd0, 64'h1122_3344_5566_7788, 2'b10, 4'd1, 64'h77, 1'b1);
        do_lsu_read(64'h8000_0000, 2'd3, 64'hCAFE_F00D_1234_5678, 2'b00, 4'd0,
                    64'hCAFE_F00D_1234_5678, 1'b1);

        // RLAST on beat 2 of 4: beat 2 early RLAST and beat 4 missing RLAST
        do_if_read(64'h8000_0100, 3'd3, 0, 8'b0000_0010, 8'b0000_1010);
        do_if_read(64'h8000_0140, 3'd1, 1, 8'b0000_0010, 8'h00);

        // Both clients requesting reads continuously: first tie after reset goes to IF
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 64'h8000_0010; lsu_req_size = 2'd3;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0200; if_req_len = 3'd1;
        for (int g = 0; g < 4; g++) begin
            automatic logic exp_if = ((g % 2) == 0);
            automatic int   nb     = exp_if ? 2 : 1;
            #1;
            chk("rr_grant", {if_req_ready, lsu_req_ready}, exp_if ? 2'b10 : 2'b01);
            tick(); #1;
            chk("rr_single_ar", {axi_arvalid, if_req_ready, lsu_req_ready}, 3'b100);
            chk("rr_arid", axi_arid, exp_if ? 4'd0 : 4'd1);
            axi_arready = 1'b1; tick(); axi_arready = 1'b0;
            for (int k = 0; k < nb; k++) begin
                axi_rvalid = 1'b1; axi_rid = exp_if ? 4'd0 : 4'd1; axi_rresp = 2'b00;
                axi_rlast = (k == nb - 1); axi_rdata = 64'(k);
                #1;
                chk("rr_no_regrant", {if_req_ready, lsu_req_ready}, 2'b00);
                tick();
            end
            axi_rvalid = 1'b0; axi_rlast = 1'b0;
        end
        lsu_req_valid = 1'b0; if_req_valid = 1'b0;
        tick();

        // Reset with an IF read in R_DATA and an LSU write in W_SEND
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 64'h8000_0008;
        lsu_req_size = 2'd3; lsu_req_wdata = 64'h1;
        tick();
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0300; if_req_len = 3'd3;
        #1;
        chk("ovl_if_ready", {if_req_ready, lsu_req_ready}, 2'b10);
        tick();
        if_req_valid = 1'b0;
        axi_arready = 1'b1; tick(); axi_arready = 1'b0;
        #1;
        chk("pre_rst", {axi_rready, axi_awvalid, axi_wvalid, axi_arvalid}, 4'b1110);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready,
                          if_rsp_valid, lsu_rsp_valid}, 7'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        do_if_read(64'h8000_0400, 3'd2, 1, 8'b0000_0100, 8'h00);
        do_lsu_write(64'h8000_0002, 2'd1, 64'h55AA, 2, 2'b00, 8'h0C, 64'h0000_0000_55AA_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
